// File: rtl/cpu_run_controller_pkg.sv
// cpu_run_controller_pkg: state encoding and shared widths for the run controller.
package cpu_run_controller_pkg;
    localparam int STATE_W = 3;
    localparam int PC_WIDTH_DEFAULT = 8;
    typedef enum logic [STATE_W-1:0] {
        RESET_HOLD = 3'd0,
        HALTED     = 3'd1,
        RUNNING    = 3'd2,
        STEPPING   = 3'd3,
        BREAK      = 3'd4
    } state_t;
endpackage

// File: rtl/cpu_run_controller_saturating_counter.sv
// cpu_run_controller_saturating_counter: up counter with sync clear that sticks at all-ones.
module cpu_run_controller_saturating_counter #(
    parameter int WIDTH = 16
) (
    input  logic             i_clock,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [WIDTH-1:0] o_count
);
    logic [WIDTH-1:0] r_count;
    always_ff @(posedge i_clock) begin
        if (i_clear) r_count <= '0;
        else if (i_enable && !(&r_count)) r_count <= r_count + 1'b1;
    end
    assign o_count = r_count;
endmodule

// File: rtl/cpu_run_controller.sv
// cpu_run_controller: run/halt/step sequencer producing the CPU advance enable and stretched reset,
// with a PC breakpoint and a saturating retired-instruction count.
module cpu_run_controller
    import cpu_run_controller_pkg::*;
#(
    parameter int PC_WIDTH          = PC_WIDTH_DEFAULT,
    parameter int COUNT_WIDTH       = 16,
    parameter int RESET_HOLD_CYCLES = 4,
    parameter int START_RUNNING     = 0
) (
    input  logic                   i_clock,
    input  logic                   i_is_reset,
    input  logic                   i_run_request,
    input  logic                   i_halt_request,
    input  logic                   i_step_request,
    input  logic                   i_break_enable,
    input  logic [PC_WIDTH-1:0]    i_break_address,
    input  logic [PC_WIDTH-1:0]    i_pc,
    output logic                   o_cpu_enable,
    output logic                   o_cpu_reset,
    output logic [STATE_W-1:0]     o_state,
    output logic                   o_break_hit,
    output logic [COUNT_WIDTH-1:0] o_instruction_count
);
    localparam int HOLD_W = $clog2(RESET_HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_HOLD_CYCLES - 1);

    state_t            r_state;
    state_t            w_next;
    logic [HOLD_W-1:0] r_hold;
    logic              r_skip;
    logic              r_break_hit;
    logic              w_break_match;
    logic              w_enable;
    logic              w_set_skip;
    logic              w_set_hit;
    logic              w_clr_hit;

    always_comb begin
        w_break_match = i_break_enable && (i_pc == i_break_address) && !r_skip;
        w_next        = r_state;
        w_enable      = 1'b0;
        w_set_skip    = 1'b0;
        w_set_hit     = 1'b0;
        w_clr_hit     = 1'b0;
        case (r_state)
            RESET_HOLD: if (r_hold == '0) w_next = (START_RUNNING != 0) ? RUNNING : HALTED;
            HALTED: begin
                if (i_halt_request) w_next = HALTED;
                else if (i_step_request) begin w_next = STEPPING; w_set_skip = 1'b1; end
                else if (i_run_request) begin w_next = RUNNING; w_set_skip = 1'b1; end
            end
            RUNNING: begin
                w_enable = !w_break_match && !i_halt_request;
                if (i_halt_request) w_next = HALTED;
                else if (w_break_match) begin w_next = BREAK; w_set_hit = 1'b1; end
            end
            STEPPING: begin
                w_enable = 1'b1;
                w_next   = HALTED;
            end
            BREAK: begin
                if (i_halt_request) w_next = HALTED;
                else if (i_step_request) begin w_next = STEPPING; w_set_skip = 1'b1; w_clr_hit = 1'b1; end
                else if (i_run_request) begin w_next = RUNNING; w_set_skip = 1'b1; w_clr_hit = 1'b1; end
            end
            default: w_next = HALTED;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_is_reset) begin
            r_state     <= RESET_HOLD;
            r_hold      <= HOLD_INIT;
            r_skip      <= 1'b0;
            r_break_hit <= 1'b0;
        end else begin
            r_state     <= w_next;
            if (r_state == RESET_HOLD && r_hold != '0) r_hold <= r_hold - 1'b1;
            r_skip      <= w_set_skip ? 1'b1 : (w_enable ? 1'b0 : r_skip);
            r_break_hit <= w_set_hit ? 1'b1 : (w_clr_hit ? 1'b0 : r_break_hit);
        end
    end

    // An edge with reset asserted never advances the datapath.
    assign o_cpu_enable = w_enable && !i_is_reset;
    assign o_cpu_reset  = i_is_reset || (r_state == RESET_HOLD);
    assign o_state      = r_state;
    assign o_break_hit  = r_break_hit;

    cpu_run_controller_saturating_counter #(.WIDTH(COUNT_WIDTH)) u_count (
        .i_clock  (i_clock),
        .i_clear  (i_is_reset),
        .i_enable (o_cpu_enable),
        .o_count  (o_instruction_count)
    );
endmodule

// File: tb/tb_cpu_run_controller.sv
// tb_cpu_run_controller: directed scenarios for the run controller; a 4-bit-count twin shares all inputs.
module tb_cpu_run_controller;
    logic        clk = 1'b0;
    logic        is_reset = 1'b1;
    logic        run_req = 1'b0;
    logic        halt_req = 1'b0;
    logic        step_req = 1'b0;
    logic        break_en = 1'b0;
    logic [7:0]  break_addr = 8'd0;
    logic [7:0]  pc = 8'd0;
    logic        cpu_enable, cpu_reset, break_hit;
    logic [2:0]  state;
    logic [15:0] count;
    logic        s_cpu_enable, s_cpu_reset, s_break_hit;
    logic [2:0]  s_state;
    logic [3:0]  s_count;
    int          n_cmp = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    cpu_run_controller #(.PC_WIDTH(8), .COUNT_WIDTH(16), .RESET_HOLD_CYCLES(4), .START_RUNNING(0)) u_dut (
        .i_clock(clk), .i_is_reset(is_reset), .i_run_request(run_req), .i_halt_request(halt_req),
        .i_step_request(step_req), .i_break_enable(break_en), .i_break_address(break_addr), .i_pc(pc),
        .o_cpu_enable(cpu_enable), .o_cpu_reset(cpu_reset), .o_state(state), .o_break_hit(break_hit),
        .o_instruction_count(count)
    );

    cpu_run_controller #(.PC_WIDTH(8), .COUNT_WIDTH(4), .RESET_HOLD_CYCLES(4), .START_RUNNING(0)) u_sat (
        .i_clock(clk), .i_is_reset(is_reset), .i_run_request(run_req), .i_halt_request(halt_req),
        .i_step_request(step_req), .i_break_enable(break_en), .i_break_address(break_addr), .i_pc(pc),
        .o_cpu_enable(s_cpu_enable), .o_cpu_reset(s_cpu_reset), .o_state(s_state), .o_break_hit(s_break_hit),
        .o_instruction_count(s_count)
    );

    // Plays the CPU: PC advances on enabled edges and returns to 0 under reset.
    task automatic tick();
        logic e, r;
        #1;
        e = cpu_enable;
        r = cpu_reset;
        @(posedge clk);
        #1;
        pc = r ? 8'd0 : pc + {7'd0, e};
        run_req = 1'b0;
        halt_req = 1'b0;
        step_req = 1'b0;
    endtask

    task automatic test_reset();
        int hi = 0;
        is_reset = 1'b1;
        repeat (2) begin
            #1;
            if (cpu_reset) hi++;
            tick();
        end
        is_reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            run_req = (i == 1);
            #1;
            if (!cpu_reset) break;
            hi++;
            n_cmp++;
            if (cpu_enable !== 1'b0) begin n_fail++; $display("FAIL hold_enable cyc=%0d got=%b want=0", i, cpu_enable); end
            tick();
        end
        n_cmp++;
        if (hi != 6) begin n_fail++; $display("FAIL reset_len got=%0d want=6", hi); end
        n_cmp++;
        if (state !== 3'd1) begin n_fail++; $display("FAIL reset_state got=%0d want=1", state); end
        n_cmp++;
        if (cpu_enable !== 1'b0) begin n_fail++; $display("FAIL reset_enable got=%b want=0", cpu_enable); end
        n_cmp++;
        if (count !== 16'd0) begin n_fail++; $display("FAIL reset_count got=%0d want=0", count); end
        n_cmp++;
        if (break_hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit got=%b want=0", break_hit); end
    endtask

    task automatic test_run_break();
        break_en = 1'b1;
        break_addr = 8'd5;
        run_req = 1'b1;
        #1;
        n_cmp++;
        if (cpu_enable !== 1'b0) begin n_fail++; $display("FAIL run_latency got=%b want=0", cpu_enable); end
        tick();
        for (int i = 0; i < 30; i++) begin
            #1;
            if (state === 3'd4) break;
            tick();
        end
        n_cmp++;
        if (state !== 3'd4) begin n_fail++; $display("FAIL break_state got=%0d want=4", state); end
        n_cmp++;
        if (break_hit !== 1'b1) begin n_fail++; $display("FAIL break_hit got=%b want=1", break_hit); end
        n_cmp++;
        if (count !== 16'd5) begin n_fail++; $display("FAIL break_count got=%0d want=5", count); end
        n_cmp++;
        if (pc !== 8'd5) begin n_fail++; $display("FAIL break_pc got=%0d want=5", pc); end
        n_cmp++;
        if (cpu_enable !== 1'b0) begin n_fail++; $display("FAIL break_enable got=%b want=0", cpu_enable); end
        n_cmp++;
        if (s_count !== 4'd5) begin n_fail++; $display("FAIL break_sat_count got=%0d want=5", s_count); end
    endtask

    task automatic test_resume_break();
        run_req = 1'b1;
        tick();
        #1;
        n_cmp++;
        if (cpu_enable !== 1'b1) begin n_fail++; $display("FAIL resume_enable got=%b want=1", cpu_enable); end
        n_cmp++;
        if (break_hit !== 1'b0) begin n_fail++; $display("FAIL resume_hit got=%b want=0", break_hit); end
        tick();
        #1;
        n_cmp++;
        if (state !== 3'd2) begin n_fail++; $display("FAIL resume_state got=%0d want=2", state); end
        n_cmp++;
        if (pc !== 8'd6) begin n_fail++; $display("FAIL resume_pc got=%0d want=6", pc); end
        n_cmp++;
        if (count !== 16'd6) begin n_fail++; $display("FAIL resume_count got=%0d want=6", count); end
        halt_req = 1'b1;
        #1;
        n_cmp++;
        if (cpu_enable !== 1'b0) begin n_fail++; $display("FAIL halt_enable got=%b want=0", cpu_enable); end
        tick();
        break_en = 1'b0;
        #1;
        n_cmp++;
        if (state !== 3'd1) begin n_fail++; $display("FAIL halt_state got=%0d want=1", state); end
    endtask

    task automatic test_step();
        int pulses = 0;
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 4; j++) begin
                step_req = (j == 0);
                #1;
                if (cpu_enable === 1'b1) pulses++;
                if (j == 1) begin
                    n_cmp++;
                    if (state !== 3'd3) begin n_fail++; $display("FAIL step_state k=%0d got=%0d want=3", k, state); end
                end
                tick();
            end
            #1;
            n_cmp++;
            if (state !== 3'd1) begin n_fail++; $display("FAIL step_return k=%0d got=%0d want=1", k, state); end
        end
        n_cmp++;
        if (pulses != 3) begin n_fail++; $display("FAIL step_pulses got=%0d want=3", pulses); end
        n_cmp++;
        if (count !== 16'd9) begin n_fail++; $display("FAIL step_count got=%0d want=9", count); end
    endtask

    task automatic test_back_to_back();
        run_req = 1'b1;
        tick();
        tick();
        halt_req = 1'b1;
        run_req = 1'b1;
        #1;
        n_cmp++;
        if (cpu_enable !== 1'b0) begin n_fail++; $display("FAIL halt_run_enable got=%b want=0", cpu_enable); end
        tick();
        #1;
        n_cmp++;
        if (state !== 3'd1) begin n_fail++; $display("FAIL halt_run_state got=%0d want=1", state); end
        n_cmp++;
        if (count !== 16'd10) begin n_fail++; $display("FAIL halt_run_count got=%0d want=10", count); end
        run_req = 1'b1;
        tick();
        tick();
        is_reset = 1'b1;
        tick();
        #1;
        n_cmp++;
        if (state !== 3'd0) begin n_fail++; $display("FAIL midreset_state got=%0d want=0", state); end
        n_cmp++;
        if (count !== 16'd0) begin n_fail++; $display("FAIL midreset_count got=%0d want=0", count); end
        n_cmp++;
        if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL midreset_cpu_reset got=%b want=1", cpu_reset); end
        is_reset = 1'b0;
        repeat (4) tick();
        #1;
        n_cmp++;
        if (state !== 3'd1) begin n_fail++; $display("FAIL midreset_exit got=%0d want=1", state); end
    endtask

    task automatic test_saturate();
        run_req = 1'b1;
        tick();
        repeat (20) tick();
        #1;
        n_cmp++;
        if (count !== 16'd20) begin n_fail++; $display("FAIL sat_main got=%0d want=20", count); end
        n_cmp++;
        if (s_count !== 4'd15) begin n_fail++; $display("FAIL sat_count got=%0d want=15", s_count); end
        n_cmp++;
        if (state !== 3'd2) begin n_fail++; $display("FAIL sat_state got=%0d want=2", state); end
        halt_req = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_run_break();
        test_resume_break();
        test_step();
        test_back_to_back();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
Run/halt/single-step sequencer for the CPU datapath (PC, register file, ALU writeback).
- Generates a per-cycle advance enable, which gates PC update and register writes, and a stretched datapath reset.
- Stops execution at a PC breakpoint and keeps a retired-instruction count.
- Sits between the board-level buttons/switches (or a debug front end) and the CPU core.

Parameters:
PC_WIDTH, 8, width of pc and breakAddress
COUNT_WIDTH, 16, width of instructionCount (saturating)
RESET_HOLD_CYCLES, 4, cycles cpuReset stays asserted after isReset deasserts (>=1)
START_RUNNING, 0, 1 = enter RUNNING after reset hold, 0 = enter HALTED

Ports:
clock  in  1  single system clock, all state on posedge
isReset  in  1  synchronous, active-high reset
runRequest  in  1  one-cycle pulse: start or resume free-running execution
haltRequest  in  1  one-cycle pulse: stop execution
stepRequest  in  1  one-cycle pulse: execute exactly one instruction
breakEnable  in  1  breakpoint comparator enable (level)
breakAddress  in  PC_WIDTH  breakpoint PC
pc  in  PC_WIDTH  current PC from the CPU
cpuEnable  out  1  datapath advances on this clock edge when 1
cpuReset  out  1  reset to PC/registers (drives the CPU's reset input)
state  out  3  current FSM state code
breakHit  out  1  sticky: execution stopped on breakpoint
instructionCount  out  COUNT_WIDTH  cycles with cpuEnable=1, saturating

Behaviour:
- States (package encoding): RESET_HOLD=0, HALTED=1, RUNNING=2, STEPPING=3, BREAK=4. Codes 5-7 are illegal and recover to HALTED on the next edge.
- isReset sampled high at an edge causes the following at that edge, overriding everything:
  - state=RESET_HOLD, holdCounter=RESET_HOLD_CYCLES-1
  - breakHit=0, instructionCount=0, skipBreak=0
- cpuReset=1 whenever isReset=1 or state==RESET_HOLD (combinational), so it is high from the first reset cycle.
- RESET_HOLD:
  - cpuEnable=0. holdCounter decrements each edge while isReset=0.
  - At 0: go to RUNNING if START_RUNNING=1, else HALTED.
  - cpuReset therefore lasts RESET_HOLD_CYCLES cycles after isReset falls.
  - run/halt/step requests are ignored and not latched.
- HALTED: cpuEnable=0.
  - Request priority: haltRequest > stepRequest > runRequest.
  - step -> STEPPING; run -> RUNNING. Either sets skipBreak=1.
- RUNNING:
  - breakMatch = breakEnable && pc==breakAddress && !skipBreak.
  - cpuEnable = !breakMatch && !haltRequest (combinational), so the instruction at breakAddress is not executed and a halt pulse stops the current cycle.
  - haltRequest -> HALTED. Else breakMatch -> BREAK and breakHit<=1.
  - skipBreak clears on the first cycle with cpuEnable=1.
- STEPPING:
  - cpuEnable=1 for exactly one cycle, ignoring the breakpoint; then HALTED. skipBreak<=0.
  - Requests during STEPPING are ignored.
- BREAK: cpuEnable=0 and breakHit stays 1.
  - Request priority: haltRequest -> HALTED (breakHit stays 1).
  - stepRequest -> STEPPING. runRequest -> RUNNING.
  - Step or run clears breakHit and sets skipBreak, so a resume at the breakpoint PC executes that instruction once.
- Request-to-enable latency: a request pulse at edge N changes state at N; cpuEnable=1 in the cycle after N.
- instructionCount increments on every edge where cpuEnable=1 and isReset=0. It holds at all-ones and does not wrap.
- state, breakHit, instructionCount, holdCounter and skipBreak are registered. cpuEnable and cpuReset are combinational from state, isReset, pc and the requests. No other combinational input-to-output paths.
- Simultaneous requests resolve by the priorities above. isReset dominates all.

Decomposition:
- Shared package: state encoding constants (RESET_HOLD..BREAK), state width 3, PC_WIDTH default shared with the PC module.
- One natural sub-module: saturating_counter (COUNT_WIDTH, enable, sync clear), used for instructionCount.
- holdCounter stays inline.

Test Plan:
- RESET_HOLD_CYCLES=4, START_RUNNING=0; isReset high 2 cycles then low -> cpuReset high 6 cycles total, then state=1, cpuEnable=0, instructionCount=0.
- From HALTED, runRequest pulse; pc counts 0,1,2...; breakEnable=1, breakAddress=5 -> cpuEnable low when pc=5, state=4, breakHit=1, instructionCount=5.
- In BREAK at pc=5, runRequest -> instruction at 5 executes (pc becomes 6), no re-break, breakHit=0, state=2.
- From HALTED, three stepRequest pulses 4 cycles apart -> exactly 3 single-cycle cpuEnable pulses, instructionCount=3, state returns to 1 after each.
- In RUNNING, haltRequest and runRequest in the same cycle -> state=1, cpuEnable=0 that cycle; isReset asserted mid-RUNNING -> state=0, count=0 next edge.
- COUNT_WIDTH=4, run 20 cycles -> instructionCount saturates at 15.
